obs_readout: RTL and testbench
==============================

OBS_READOUT -- requirements
Module: obs_readout

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, max cycles dbg_req waits for dbg_ack before abort.
REQ-002 Parameter: ERR_WORD, default 32'hFFFF_FFFF, word substituted for read data on timeout.
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pulse  in  1  change pulse from the observe-select pulse generator (high 2 consecutive cycles per change).
REQ-006 observ  in  5  observe-select index (register number).
REQ-007 dbg_req  out  1  debug read request to register-file debug port.
REQ-008 dbg_addr  out  5  debug read address, valid while dbg_req=1.
REQ-009 dbg_ack  in  1  read complete; dbg_data valid in same cycle.
REQ-010 dbg_data  in  32  read data.
REQ-011 nib  out  4  hex digit to display driver.
REQ-012 nib_idx  out  3  digit position, 7 = most significant.
REQ-013 nib_valid  out  1  nib/nib_idx valid.
REQ-014 nib_ready  in  1  display driver accepts digit.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 err  out  1  high while the current frame carries ERR_WORD due to timeout.

Function
REQ-017 Trigger SHALL be the rising edge of pulse (pulse=1, previous-cycle pulse=0); a 2-cycle pulse yields exactly one trigger.
REQ-018 FSM states SHALL be IDLE, REQ, SHIFT.
REQ-019 IDLE: on trigger, latch observ into dbg_addr, clear timeout counter, go REQ; dbg_req=1 on the next cycle.
REQ-020 REQ: dbg_req=1, dbg_addr stable; in a cycle with dbg_ack=1, capture dbg_data into a 32-bit shift register, err<=0, go SHIFT; dbg_req=0 from the next cycle.
REQ-021 REQ: if the timeout counter reaches TIMEOUT_CYC with no dbg_ack, load ERR_WORD, err<=1, go SHIFT; an ack in that same cycle SHALL take priority (data captured, err=0).
REQ-022 SHIFT: nib_valid=1, nib = shift-register bits [31:28] of remaining word, nib_idx starts at 7.
REQ-023 Transfer occurs when nib_valid&&nib_ready; on transfer shift left by 4 and decrement nib_idx.
REQ-024 While nib_valid&&!nib_ready, nib and nib_idx SHALL hold stable.
REQ-025 On the transfer with nib_idx=0: if pending=1, re-latch observ, clear pending, go REQ; else go IDLE; nib_valid=0 next cycle unless pending.
REQ-026 A trigger in REQ or SHIFT SHALL set a single pending flag (multiple triggers coalesce); the current frame is not aborted.
REQ-027 dbg_ack in IDLE or SHIFT SHALL be ignored.
REQ-028 Timeout counter SHALL saturate and not wrap; width ceil(log2(TIMEOUT_CYC+1)).
REQ-029 err SHALL hold its value until the next capture in REQ.
REQ-030 Minimum latency: trigger cycle T -> dbg_req at T+1; ack at T+1 -> first nib_valid at T+2; 8 digits with nib_ready=1 tie-off end at T+9.

Reset
REQ-031 rst=1 SHALL force IDLE, dbg_req=0, dbg_addr=0, nib=0, nib_idx=7, nib_valid=0, busy=0, err=0, pending=0, pulse-history=0, counters=0.
REQ-032 rst mid-frame SHALL abandon the frame with no further digit or request; pulse high at deassertion SHALL NOT trigger until it falls and rises again.

Structure
REQ-033 Shared package: FSM state encoding, digit count (8), default TIMEOUT_CYC and ERR_WORD.
REQ-034 One sub-module natural: obs_edge_det (1-bit rising-edge detector with synchronous reset).

Verification
REQ-035 observ=5'd3, 2-cycle pulse, ack one cycle after req with 32'h1234_ABCD, nib_ready=1 -> one request at addr 3; digits 1,2,3,4,A,B,C,D with idx 7..0; err=0.
REQ-036 nib_ready toggled 1,0,0,1... -> nib/nib_idx held during stalls; full 8-digit order intact; no digit dropped or duplicated.
REQ-037 No dbg_ack, TIMEOUT_CYC=4 -> dbg_req high exactly 5 cycles, then 8 digits of F, err=1; next good read clears err.
REQ-038 Three pulses during SHIFT with observ ending at 5'd9 -> exactly one follow-up request at addr 9 right after idx 0 transfer.
REQ-039 rst asserted during SHIFT at idx 4 -> next cycle nib_valid=0, busy=0, IDLE; no request until a new rising pulse.
REQ-040 Ack arriving in the timeout-expiry cycle -> data captured, err=0.

Source files
------------

// File: rtl/obs_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obs_readout_pkg
// Description : Shared types and constants for the observe-select readout.
//               FSM state encoding, digit count, default timeout and the
//               substitute word used when a debug read times out.
// Revision    : 1.0 - initial release
// ============================================================================
package obs_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam int          c_addr_w          = 5;
  localparam int          c_data_w          = 32;
  localparam int          c_nib_w           = 4;
  localparam int          c_idx_w           = 3;
  localparam int unsigned c_num_digits      = 8;
  localparam int unsigned c_def_timeout_cyc = 255;
  localparam logic [c_data_w-1:0] c_def_err_word = 32'hFFFF_FFFF;

  // Index of the most significant digit; the first digit of every frame.
  localparam logic [c_idx_w-1:0] c_first_idx = c_idx_w'(c_num_digits - 1);

endpackage : obs_readout_pkg
`default_nettype wire

// File: rtl/obs_readout_if.sv
`default_nettype none
// ============================================================================
// Module      : obs_readout_if
// Description : Bundles the register-file debug read port and the hex-digit
//               stream to the display driver.
//   dbg_req/dbg_addr   : read request and address (readout -> regfile)
//   dbg_ack/dbg_data   : read complete and data   (regfile -> readout)
//   nib/nib_idx/valid  : digit, position, valid   (readout -> display)
//   nib_ready          : digit accepted           (display -> readout)
// Revision    : 1.0 - initial release
// ============================================================================
interface obs_readout_if;
  import obs_readout_pkg::*;

  logic                dbg_req;
  logic [c_addr_w-1:0] dbg_addr;
  logic                dbg_ack;
  logic [c_data_w-1:0] dbg_data;
  logic [c_nib_w-1:0]  nib;
  logic [c_idx_w-1:0]  nib_idx;
  logic                nib_valid;
  logic                nib_ready;

  modport master (
    output dbg_req, dbg_addr, nib, nib_idx, nib_valid,
    input  dbg_ack, dbg_data, nib_ready
  );

  modport slave (
    input  dbg_req, dbg_addr, nib, nib_idx, nib_valid,
    output dbg_ack, dbg_data, nib_ready
  );

endinterface : obs_readout_if
`default_nettype wire

// File: rtl/obs_readout_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : obs_edge_det
// Description : 1-bit rising-edge detector with synchronous reset.
//   clk, rst : clock and synchronous active-high reset
//   i_d      : level input
//   o_rise   : high for the cycle in which i_d is 1 and was 0 the cycle before
// Revision    : 1.0 - initial release
// ============================================================================
module obs_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;
  // Set by reset and released once i_d is seen low, so an input that is
  // already high when reset drops does not count as a rising edge.
  logic r_block;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_block <= 1'b1;
    end else begin
      r_prev <= i_d;
      if (!i_d) begin
        r_block <= 1'b0;
      end
    end
  end

  assign o_rise = i_d & ~r_prev & ~r_block;

endmodule : obs_edge_det
`default_nettype wire

// File: rtl/obs_readout.sv
`default_nettype none
// ============================================================================
// Module      : obs_readout
// Description : On each observe-select change, reads the selected register
//               through the debug port and streams it to the display as
//               eight hex digits, most significant first. A read that is not
//               acknowledged within TIMEOUT_CYC cycles shows ERR_WORD.
//   clk, rst   : clock, synchronous active-high reset
//   i_pulse    : change pulse (2 cycles per change); rising edge triggers
//   i_observ   : register index to read
//   bus        : debug read port and digit stream (master side)
//   o_busy     : high whenever the FSM is not idle
//   o_err      : current frame carries ERR_WORD due to timeout
// Revision    : 1.0 - initial release
// ============================================================================
module obs_readout
  import obs_readout_pkg::*;
#(
  parameter int unsigned         TIMEOUT_CYC = c_def_timeout_cyc,
  parameter logic [c_data_w-1:0] ERR_WORD    = c_def_err_word
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_pulse,
  input  logic [c_addr_w-1:0] i_observ,
  obs_readout_if.master       bus,
  output logic                o_busy,
  output logic                o_err
);

  localparam int c_cnt_w = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_tmo = c_cnt_w'(TIMEOUT_CYC);

  state_t              r_state;
  state_t              w_next;
  logic [c_addr_w-1:0] r_addr;
  logic [c_data_w-1:0] r_shift;
  logic [c_idx_w-1:0]  r_idx;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_err;
  logic                r_pending;

  logic w_trig;
  logic w_ack;
  logic w_tmo;
  logic w_xfer;
  logic w_last;
  logic w_load_addr;

  obs_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_d    (i_pulse),
    .o_rise (w_trig)
  );

  always_comb begin
    w_next      = r_state;
    w_ack       = 1'b0;
    w_tmo       = 1'b0;
    w_xfer      = 1'b0;
    w_last      = 1'b0;
    w_load_addr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_next      = ST_REQ;
          w_load_addr = 1'b1;
        end
      end
      ST_REQ: begin
        // An ack in the expiry cycle wins over the timeout.
        if (bus.dbg_ack) begin
          w_ack  = 1'b1;
          w_next = ST_SHIFT;
        end else if (r_cnt == c_tmo) begin
          w_tmo  = 1'b1;
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.nib_ready) begin
          w_xfer = 1'b1;
          if (r_idx == '0) begin
            w_last = 1'b1;
            // A trigger landing on the final transfer is folded into the
            // pending request rather than being lost on the way to idle.
            if (r_pending || w_trig) begin
              w_next      = ST_REQ;
              w_load_addr = 1'b1;
            end else begin
              w_next = ST_IDLE;
            end
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_shift   <= '0;
      r_idx     <= c_first_idx;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_load_addr) begin
        r_addr <= i_observ;
        r_cnt  <= '0;
      end else if ((r_state == ST_REQ) && (r_cnt != c_tmo)) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end

      if (w_ack) begin
        r_shift <= bus.dbg_data;
        r_idx   <= c_first_idx;
        r_err   <= 1'b0;
      end else if (w_tmo) begin
        r_shift <= ERR_WORD;
        r_idx   <= c_first_idx;
        r_err   <= 1'b1;
      end else if (w_xfer) begin
        r_shift <= {r_shift[c_data_w-c_nib_w-1:0], {c_nib_w{1'b0}}};
        r_idx   <= r_idx - c_idx_w'(1);
      end

      if (w_last) begin
        r_pending <= 1'b0;
      end else if (w_trig && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign bus.dbg_req   = (r_state == ST_REQ);
  assign bus.dbg_addr  = r_addr;
  assign bus.nib_valid = (r_state == ST_SHIFT);
  assign bus.nib       = r_shift[c_data_w-1 -: c_nib_w];
  assign bus.nib_idx   = r_idx;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_err         = r_err;

endmodule : obs_readout
`default_nettype wire

// File: tb/tb_obs_readout.sv
`default_nettype none
// ============================================================================
// Module      : tb_obs_readout
// Description : Self-checking bench for obs_readout. Plays the register file
//               and the display driver, records every request and digit
//               transfer, and compares against frames built from the read
//               word (digit i = word >> 4*i).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obs_readout;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       pulse  = 1'b0;
  logic [4:0] observ = 5'd0;
  logic       busy;
  logic       err;

  obs_readout_if bus();

  obs_readout #(.TIMEOUT_CYC(TMO), .ERR_WORD(ERR)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_pulse  (pulse),
    .i_observ (observ),
    .bus      (bus),
    .o_busy   (busy),
    .o_err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int nib;
    int cyc;
  } dig_t;

  int          checks    = 0;
  int          failures  = 0;
  int          cyc       = 0;
  int          ack_delay = 0;
  int          ready_mode = 0;
  int          rdy_ph    = 0;
  int          req_len   = 0;
  int          req_total = 0;
  bit          noise_en  = 1'b0;
  logic [31:0] rd_data   = 32'h0;
  int          req_addr_q[$];
  int          req_start_q[$];
  dig_t        dig_q[$];
  bit          prev_stall = 1'b0;
  logic [3:0]  prev_nib   = 4'h0;
  logic [2:0]  prev_idx   = 3'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    req_addr_q.delete();
    req_start_q.delete();
    dig_q.delete();
    req_total = 0;
  endtask

  // One clock: advance past the edge, observe, then answer as regfile/display.
  task automatic step();
    bit   rdy;
    dig_t d;
    @(posedge clk);
    #1;
    cyc++;
    if (prev_stall && bus.nib_valid) begin
      check("hold_nib", 32'(bus.nib), 32'(prev_nib));
      check("hold_idx", 32'(bus.nib_idx), 32'(prev_idx));
    end
    if (bus.dbg_req) begin
      if (req_len == 0) begin
        req_addr_q.push_back(int'(bus.dbg_addr));
        req_start_q.push_back(cyc);
      end else begin
        check("addr_stable", 32'(bus.dbg_addr), 32'(req_addr_q[$]));
      end
      req_total++;
      if (req_len == ack_delay) begin
        bus.dbg_ack  = 1'b1;
        bus.dbg_data = rd_data;
      end else begin
        bus.dbg_ack  = 1'b0;
        bus.dbg_data = $urandom;
      end
      req_len++;
    end else begin
      req_len      = 0;
      bus.dbg_ack  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.dbg_data = $urandom;
    end
    case (ready_mode)
      0:       rdy = 1'b1;
      1:       rdy = ((rdy_ph % 3) == 0);
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    rdy_ph++;
    bus.nib_ready = rdy;
    if (bus.nib_valid && rdy) begin
      d.idx = int'(bus.nib_idx);
      d.nib = int'(bus.nib);
      d.cyc = cyc;
      dig_q.push_back(d);
    end
    prev_stall = bus.nib_valid && !rdy;
    prev_nib   = bus.nib;
    prev_idx   = bus.nib_idx;
  endtask

  task automatic check_digits(input string tag, input int base, input logic [31:0] word);
    for (int i = 0; i < 8; i++) begin
      if (dig_q.size() > base + i) begin
        check({tag, "_idx"}, 32'(dig_q[base+i].idx), 32'(7 - i));
        check({tag, "_nib"}, 32'(dig_q[base+i].nib), (word >> (4 * (7 - i))) & 32'hF);
      end
    end
  endtask

  task automatic fire_pulse();
    pulse = 1'b1;
    step();
    step();
    pulse = 1'b0;
  endtask

  task automatic do_frame(input string tag, input logic [4:0] addr, input logic [31:0] data,
                          input int dly, input int rmode);
    int          t_trig;
    int          guard;
    int          exp_len;
    bit          acked;
    logic [31:0] word;
    clear_rec();
    observ     = addr;
    rd_data    = data;
    ack_delay  = dly;
    ready_mode = rmode;
    rdy_ph     = 0;
    pulse      = 1'b1;
    step();
    t_trig = cyc;
    step();
    pulse = 1'b0;
    guard = 0;
    while (busy && guard < 300) begin
      step();
      guard++;
    end
    acked   = (dly >= 0) && (dly <= TMO);
    word    = acked ? data : ERR;
    exp_len = acked ? dly + 1 : TMO + 1;
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_nreq"}, 32'(req_addr_q.size()), 32'd1);
    if (req_addr_q.size() > 0) begin
      check({tag, "_addr"}, 32'(req_addr_q[0]), 32'(addr));
      check({tag, "_req_start"}, 32'(req_start_q[0]), 32'(t_trig));
    end
    check({tag, "_req_cycles"}, 32'(req_total), 32'(exp_len));
    check({tag, "_ndig"}, 32'(dig_q.size()), 32'd8);
    check_digits(tag, 0, word);
    check({tag, "_err"}, 32'(err), 32'(!acked));
    if (rmode == 0 && dig_q.size() == 8) begin
      check({tag, "_lat_first"}, 32'(dig_q[0].cyc), 32'(t_trig + exp_len));
      check({tag, "_lat_last"}, 32'(dig_q[7].cyc), 32'(t_trig + exp_len + 7));
    end
  endtask

  initial begin
    int          guard;
    logic [31:0] w;
    int          dly;
    bus.dbg_ack   = 1'b0;
    bus.dbg_data  = 32'h0;
    bus.nib_ready = 1'b1;

    // Reset with pulse held high across deassertion.
    rst   = 1'b1;
    pulse = 1'b1;
    repeat (3) step();
    check("rst_req", 32'(bus.dbg_req), 32'd0);
    check("rst_addr", 32'(bus.dbg_addr), 32'd0);
    check("rst_nib", 32'(bus.nib), 32'd0);
    check("rst_idx", 32'(bus.nib_idx), 32'd7);
    check("rst_valid", 32'(bus.nib_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    clear_rec();
    repeat (5) step();
    check("held_pulse_busy", 32'(busy), 32'd0);
    check("held_pulse_req", 32'(req_total), 32'd0);
    pulse = 1'b0;
    step();
    noise_en = 1'b1;

    // Basic read, zero-latency ack, display always ready.
    do_frame("basic", 5'd3, 32'h1234_ABCD, 0, 0);

    // Display stalls in a 1,0,0 pattern.
    do_frame("stall", 5'd21, $urandom, 1, 1);

    // No ack: timeout, ERR_WORD frame, err set; then a good read clears err.
    do_frame("timeout", 5'd17, $urandom, -1, 0);
    do_frame("clear_err", 5'd8, 32'h0F1E_2D3C, 2, 2);

    // Ack exactly in the expiry cycle wins.
    do_frame("timeout2", 5'd30, $urandom, -1, 2);
    do_frame("ack_expiry", 5'd5, 32'hCAFE_0123, TMO, 0);

    // Three triggers during SHIFT coalesce into one follow-up at addr 9.
    clear_rec();
    observ     = 5'd11;
    w          = $urandom;
    rd_data    = w;
    ack_delay  = 0;
    ready_mode = 1;
    rdy_ph     = 0;
    fire_pulse();
    guard = 0;
    while (!bus.nib_valid && guard < 20) begin
      step();
      guard++;
    end
    observ = 5'd20; fire_pulse(); step();
    observ = 5'd7;  fire_pulse(); step();
    observ = 5'd9;  fire_pulse(); step();
    check("pend_mid_frame", 32'(dig_q.size() < 8), 32'd1);
    guard = 0;
    while (busy && guard < 300) begin
      step();
      guard++;
    end
    check("pend_idle", 32'(busy), 32'd0);
    check("pend_nreq", 32'(req_addr_q.size()), 32'd2);
    check("pend_ndig", 32'(dig_q.size()), 32'd16);
    if (req_addr_q.size() == 2) begin
      check("pend_addr0", 32'(req_addr_q[0]), 32'd11);
      check("pend_addr1", 32'(req_addr_q[1]), 32'd9);
    end
    if (req_start_q.size() == 2 && dig_q.size() >= 8) begin
      check("pend_followup_cyc", 32'(req_start_q[1]), 32'(dig_q[7].cyc + 1));
    end
    check_digits("pend_f0", 0, w);
    check_digits("pend_f1", 8, w);

    // Reset in the middle of SHIFT, at digit index 4.
    clear_rec();
    observ     = 5'd14;
    rd_data    = $urandom;
    ack_delay  = 0;
    ready_mode = 0;
    fire_pulse();
    guard = 0;
    while (!(bus.nib_valid && bus.nib_idx == 3'd4) && guard < 30) begin
      step();
      guard++;
    end
    check("midrst_reached_idx4", 32'(bus.nib_idx), 32'd4);
    rst = 1'b1;
    step();
    check("midrst_valid", 32'(bus.nib_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req", 32'(bus.dbg_req), 32'd0);
    check("midrst_idx", 32'(bus.nib_idx), 32'd7);
    rst        = 1'b0;
    prev_stall = 1'b0;
    clear_rec();
    repeat (15) step();
    check("midrst_no_req", 32'(req_total), 32'd0);
    check("midrst_no_dig", 32'(dig_q.size()), 32'd0);
    do_frame("after_rst", 5'd14, 32'h89AB_CDEF, 1, 0);

    // Randomised frames; ack delays above TMO never arrive in time.
    for (int k = 0; k < 8; k++) begin
      dly = int'($urandom_range(0, 6));
      do_frame("rand", 5'($urandom), $urandom, dly, int'($urandom_range(0, 2)));
      repeat (int'($urandom_range(1, 4))) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_obs_readout
`default_nettype wire
